// File: rtl/spoof_replay_sequencer.sv
// Replays memory-fetched answers as sensor replies to CPU SPI commands: wake detect, start byte, per-byte fetch, trigger window, fetch-timeout fault.
// Latency: mem_data_send lags slave_cmd by 1 cycle, and pin/valid decisions lag by SYNC_STAGES. The memory side is throttled by the mem_go/mem_busy handshake.
module spoof_replay_sequencer #(
    parameter int               DATA_W        = 8,
    parameter int               SYNC_STAGES   = 2,
    parameter int               WAKE_CYCLES   = 23750,
    parameter int               IDLE_CYCLES   = 12500000,
    parameter logic [DATA_W-1:0] START_BYTE   = 8'hFC,
    parameter logic [DATA_W-1:0] MARK_BYTE    = 8'hC4,
    parameter logic [7:0]       MARK_COUNT    = 8'd2,
    parameter logic [15:0]      TRIG_OFFSET   = 16'h9000,
    parameter int               TRIG_LEN      = 1,
    parameter int               FETCH_TIMEOUT = 1024,
    parameter logic [DATA_W-1:0] FAULT_BYTE   = 8'hFF
) (
    input  logic              SYSCLK,
    input  logic              resetb,
    input  logic              key_spoof_n,
    input  logic              key_pass_n,
    input  logic              csn_in,
    input  logic              sclk_in,
    input  logic              mosi_in,
    input  logic              slave_valid,
    input  logic [DATA_W-1:0] slave_cmd,
    output logic [DATA_W-1:0] sensor_out,
    output logic              mem_resetb,
    output logic              mem_go,
    output logic [DATA_W-1:0] mem_data_send,
    input  logic              mem_busy,
    input  logic [DATA_W-1:0] mem_data_get,
    output logic              mode,
    output logic              time_trigger,
    output logic [1:0]        led,
    output logic              fault,
    output logic [3:0]        state_dbg,
    output logic [7:0]        mark_cnt
);

    localparam int WK_W = $clog2(WAKE_CYCLES + 2);
    localparam int ID_W = $clog2(IDLE_CYCLES + 2);
    localparam int TO_W = $clog2(FETCH_TIMEOUT + 2);
    localparam logic [16:0] TRIG_END = 17'(TRIG_OFFSET) + 17'(TRIG_LEN);

    typedef enum logic [3:0] {
        IDLE         = 4'd0,
        ARMED        = 4'd1,
        FETCH        = 4'd2,
        WAIT_BUSY    = 4'd3,
        WAIT_DONE    = 4'd4,
        LOAD         = 4'd5,
        WAIT_CONSUME = 4'd6,
        WAIT_NEXT    = 4'd7,
        FAULT        = 4'd8
    } state_t;

    state_t                   state;
    logic [SYNC_STAGES-1:0]   csn_sync, sclk_sync, mosi_sync, valid_sync;
    logic                     csn_s, sclk_s, mosi_s, valid_s;
    logic                     busy_r;
    logic [DATA_W-1:0]        data_get_r;
    logic [WK_W-1:0]          wake_cnt;
    logic [ID_W-1:0]          idle_cnt;
    logic [TO_W-1:0]          to_cnt;
    logic [15:0]              byte_cnt;
    logic                     trig_armed;
    logic                     wake_pat, idle_pat, in_window;

    always_ff @(posedge SYSCLK or negedge resetb) begin
        if (!resetb) begin
            csn_sync      <= '0;
            sclk_sync     <= '0;
            mosi_sync     <= '0;
            valid_sync    <= '0;
            mem_data_send <= '0;
            busy_r        <= 1'b0;
            data_get_r    <= '0;
        end else begin
            csn_sync      <= {csn_sync[SYNC_STAGES-2:0], csn_in};
            sclk_sync     <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            mosi_sync     <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
            valid_sync    <= {valid_sync[SYNC_STAGES-2:0], slave_valid};
            mem_data_send <= slave_cmd;
            busy_r        <= mem_busy;
            data_get_r    <= mem_data_get;
        end
    end

    assign csn_s     = csn_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign valid_s   = valid_sync[SYNC_STAGES-1];
    // Sensor wake: CS high, clock low, MOSI high. Bus idle: all three low.
    assign wake_pat  = csn_s & ~sclk_s & mosi_s;
    assign idle_pat  = ~csn_s & ~sclk_s & ~mosi_s;
    assign in_window = ({1'b0, byte_cnt} >= {1'b0, TRIG_OFFSET}) && ({1'b0, byte_cnt} < TRIG_END);

    assign time_trigger = trig_armed & mosi_in;
    assign state_dbg    = state;

    always_ff @(posedge SYSCLK or negedge resetb) begin
        if (!resetb) begin
            state      <= IDLE;
            sensor_out <= '0;
            mem_resetb <= 1'b0;
            mem_go     <= 1'b0;
            mode       <= 1'b0;
            led        <= 2'b00;
            fault      <= 1'b0;
            mark_cnt   <= '0;
            wake_cnt   <= '0;
            idle_cnt   <= '0;
            to_cnt     <= '0;
            byte_cnt   <= '0;
            trig_armed <= 1'b0;
        end else if (!key_pass_n) begin
            state      <= IDLE;
            mode       <= 1'b1;
            led        <= 2'b11;
            wake_cnt   <= '0;
            idle_cnt   <= '0;
            mem_go     <= 1'b0;
            mem_resetb <= 1'b0;
        end else if (!key_spoof_n) begin
            state      <= IDLE;
            mode       <= 1'b0;
            led        <= 2'b00;
            wake_cnt   <= '0;
            idle_cnt   <= '0;
            mem_go     <= 1'b0;
            mem_resetb <= 1'b0;
        end else if (state != IDLE && idle_cnt > ID_W'(IDLE_CYCLES)) begin
            // fault stays set so the cause is still visible until the next arm
            state      <= IDLE;
            idle_cnt   <= '0;
            mem_go     <= 1'b0;
            mem_resetb <= 1'b0;
        end else begin
            if (state != IDLE && idle_pat)
                idle_cnt <= idle_cnt + 1'b1;
            else
                idle_cnt <= '0;

            case (state)
                IDLE: begin
                    sensor_out <= '0;
                    mem_resetb <= 1'b0;
                    mem_go     <= 1'b0;
                    if (wake_pat) begin
                        if (wake_cnt > WK_W'(WAKE_CYCLES)) begin
                            state    <= ARMED;
                            wake_cnt <= '0;
                        end else begin
                            wake_cnt <= wake_cnt + 1'b1;
                        end
                    end else begin
                        wake_cnt <= '0;
                    end
                end
                ARMED: begin
                    mark_cnt   <= '0;
                    byte_cnt   <= '0;
                    trig_armed <= 1'b0;
                    fault      <= 1'b0;
                    sensor_out <= '0;
                    if (mem_data_send == START_BYTE) begin
                        mem_resetb <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    mem_go <= 1'b1;
                    to_cnt <= '0;
                    if (mem_data_send == MARK_BYTE && mark_cnt != 8'hFF)
                        mark_cnt <= mark_cnt + 8'd1;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (busy_r) begin
                        mem_go <= 1'b0;
                        state  <= WAIT_DONE;
                    end else if (to_cnt >= TO_W'(FETCH_TIMEOUT)) begin
                        state <= FAULT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!busy_r)
                        state <= LOAD;
                end
                LOAD: begin
                    sensor_out <= data_get_r;
                    state      <= WAIT_CONSUME;
                end
                WAIT_CONSUME: begin
                    if (!valid_s) begin
                        // window test uses the byte index before this byte is counted
                        trig_armed <= in_window;
                        if (mark_cnt == MARK_COUNT && byte_cnt != 16'hFFFF)
                            byte_cnt <= byte_cnt + 16'd1;
                        state <= WAIT_NEXT;
                    end
                end
                WAIT_NEXT: begin
                    if (valid_s)
                        state <= FETCH;
                end
                FAULT: begin
                    mem_go     <= 1'b0;
                    fault      <= 1'b1;
                    sensor_out <= FAULT_BYTE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spoof_replay_sequencer.sv
// Bench for spoof_replay_sequencer: random command bytes against a behavioural memory/answer model,
// plus wake, trigger window, fetch fault, keys and async reset scenarios with shortened timeouts.
module tb_spoof_replay_sequencer;

    localparam int          WAKE  = 20;
    localparam int          IDLEC = 50;
    localparam int          FTO   = 16;
    localparam int          MARKS = 2;
    localparam int          TOFF  = 4;
    localparam int          TLEN  = 2;
    localparam logic [7:0]  START = 8'hFC;
    localparam logic [7:0]  MARK  = 8'hC4;
    localparam logic [7:0]  XKEY  = 8'hA6;

    logic       SYSCLK = 1'b0;
    logic       resetb = 1'b0;
    logic       key_spoof_n = 1'b1, key_pass_n = 1'b1;
    logic       csn_in = 1'b1, sclk_in = 1'b1, mosi_in = 1'b1;
    logic       slave_valid = 1'b0;
    logic [7:0] slave_cmd = 8'h00;
    logic [7:0] sensor_out, mem_data_send;
    logic [7:0] mem_data_get = 8'h00;
    logic       mem_busy = 1'b0;
    logic       mem_resetb, mem_go, mode, time_trigger, fault;
    logic [1:0] led;
    logic [3:0] state_dbg;
    logic [7:0] mark_cnt;

    int total = 0;
    int bad = 0;

    // memory model controls and observations
    logic       mem_stuck = 1'b0;
    logic       long_busy = 1'b0;
    int         mm_phase = 0, mm_wait = 0, mm_len = 0, go_seen = 0;
    logic [7:0] mm_cmd = 8'h00;

    spoof_replay_sequencer #(
        .DATA_W(8), .SYNC_STAGES(2), .WAKE_CYCLES(WAKE), .IDLE_CYCLES(IDLEC),
        .START_BYTE(START), .MARK_BYTE(MARK), .MARK_COUNT(8'(MARKS)),
        .TRIG_OFFSET(16'(TOFF)), .TRIG_LEN(TLEN), .FETCH_TIMEOUT(FTO), .FAULT_BYTE(8'hFF)
    ) dut (
        .SYSCLK(SYSCLK), .resetb(resetb), .key_spoof_n(key_spoof_n), .key_pass_n(key_pass_n),
        .csn_in(csn_in), .sclk_in(sclk_in), .mosi_in(mosi_in),
        .slave_valid(slave_valid), .slave_cmd(slave_cmd), .sensor_out(sensor_out),
        .mem_resetb(mem_resetb), .mem_go(mem_go), .mem_data_send(mem_data_send),
        .mem_busy(mem_busy), .mem_data_get(mem_data_get), .mode(mode),
        .time_trigger(time_trigger), .led(led), .fault(fault),
        .state_dbg(state_dbg), .mark_cnt(mark_cnt)
    );

    always #5 SYSCLK = ~SYSCLK;

    // Memory slave: on mem_go, go busy after a short random delay, then return cmd ^ XKEY.
    always @(negedge SYSCLK) begin
        if (!mem_resetb) begin
            mem_busy = 1'b0;
            mm_phase = 0;
        end else begin
            case (mm_phase)
                0: if (mem_go && !mem_stuck) begin
                    mm_cmd  = mem_data_send;
                    mm_wait = $urandom_range(0, 2);
                    mm_len  = long_busy ? 40 : $urandom_range(1, 4);
                    go_seen = go_seen + 1;
                    mm_phase = 1;
                end
                1: if (mm_wait == 0) begin
                    mem_busy = 1'b1;
                    mm_phase = 2;
                end else mm_wait = mm_wait - 1;
                2: if (mm_len == 0) begin
                    mem_busy     = 1'b0;
                    mem_data_get = mm_cmd ^ XKEY;
                    mm_phase     = 3;
                end else mm_len = mm_len - 1;
                default: if (!mem_go) mm_phase = 0;
            endcase
        end
    end

    task automatic wait_state(input logic [3:0] target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge SYSCLK);
            if (state_dbg == target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic key_spoof_pulse();
        key_spoof_n = 1'b0;
        @(negedge SYSCLK);
        key_spoof_n = 1'b1;
        @(negedge SYSCLK);
    endtask

    task automatic wake_up(output bit ok);
        slave_valid = 1'b0;
        slave_cmd   = 8'h00;
        csn_in = 1'b1; sclk_in = 1'b0; mosi_in = 1'b1;
        wait_state(4'd1, WAKE + 20, ok);
        csn_in = 1'b0; sclk_in = 1'b1; mosi_in = 1'b1;
    endtask

    // One CPU byte: present it with valid, wait for the answer load, then drop valid.
    task automatic send_byte(input logic [7:0] cmd, output bit ok);
        slave_cmd   = cmd;
        slave_valid = 1'b1;
        wait_state(4'd6, 200, ok);
        if (ok) begin
            slave_valid = 1'b0;
            wait_state(4'd7, 50, ok);
        end
    endtask

    task automatic test_reset();
        @(negedge SYSCLK);
        total++;
        if (state_dbg !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
        total++;
        if ({mem_go, mem_resetb} !== 2'b00) begin bad++; $display("FAIL reset_mem got=%b exp=00", {mem_go, mem_resetb}); end
        total++;
        if ({sensor_out, mark_cnt} !== 16'h0) begin bad++; $display("FAIL reset_data got=%h exp=0000", {sensor_out, mark_cnt}); end
        total++;
        if ({mode, led, fault, time_trigger} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {mode, led, fault, time_trigger}); end
        resetb = 1'b1;
        @(negedge SYSCLK);
    endtask

    task automatic test_wake();
        csn_in = 1'b1; sclk_in = 1'b0; mosi_in = 1'b1;
        repeat (WAKE - 5) @(negedge SYSCLK);
        mosi_in = 1'b0;
        @(negedge SYSCLK);
        mosi_in = 1'b1;
        repeat (WAKE - 5) @(negedge SYSCLK);
        total++;
        if (state_dbg !== 4'd0) begin bad++; $display("FAIL wake_glitch got=%0d exp=0", state_dbg); end
        repeat (10) @(negedge SYSCLK);
        total++;
        if (state_dbg !== 4'd1) begin bad++; $display("FAIL wake_armed got=%0d exp=1", state_dbg); end
        csn_in = 1'b0; sclk_in = 1'b1;
        repeat (4) @(negedge SYSCLK);
        total++;
        if ({state_dbg, mem_resetb} !== {4'd1, 1'b0}) begin bad++; $display("FAIL armed_hold got=%h exp=2", {state_dbg, mem_resetb}); end
    endtask

    task automatic test_replay();
        bit         ok;
        int         g0;
        logic [7:0] cmd;
        g0 = go_seen;
        send_byte(START, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL replay_start_timeout got=%0d exp=7", state_dbg); end
        total++;
        if (mem_resetb !== 1'b1) begin bad++; $display("FAIL replay_mem_resetb got=%b exp=1", mem_resetb); end
        total++;
        if (go_seen != g0 + 1 || mm_cmd !== START) begin bad++; $display("FAIL replay_go got=%0d/%h exp=%0d/%h", go_seen, mm_cmd, g0 + 1, START); end
        total++;
        if (sensor_out !== 8'h5A) begin bad++; $display("FAIL replay_answer got=%h exp=5a", sensor_out); end
        for (int i = 0; i < 8; i++) begin
            cmd = 8'($urandom_range(0, 255));
            if (cmd == MARK) cmd = 8'h00;
            g0 = go_seen;
            send_byte(cmd, ok);
            total++;
            if (!ok || go_seen != g0 + 1 || mm_cmd !== cmd) begin
                bad++; $display("FAIL replay_fetch%0d got=%h go=%0d exp=%h go=%0d", i, mm_cmd, go_seen, cmd, g0 + 1);
            end
            total++;
            if (sensor_out !== (cmd ^ XKEY)) begin bad++; $display("FAIL replay_ans%0d got=%h exp=%h", i, sensor_out, cmd ^ XKEY); end
        end
        total++;
        if (mark_cnt !== 8'd0) begin bad++; $display("FAIL replay_marks got=%0d exp=0", mark_cnt); end
    endtask

    task automatic test_trigger();
        bit         ok;
        logic [7:0] cmd;
        int         marks, idx;
        bit         exp_trig;
        key_spoof_pulse();
        wake_up(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL trig_wake got=%0d exp=1", state_dbg); end
        marks = 0;
        idx   = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) cmd = START;
            else if (i < 3) cmd = MARK;
            else begin
                cmd = 8'($urandom_range(0, 255));
                if (cmd == MARK) cmd = 8'h11;
            end
            send_byte(cmd, ok);
            if (cmd == MARK && marks < 255) marks++;
            exp_trig = (idx >= TOFF) && (idx < TOFF + TLEN);
            if (marks == MARKS) idx++;
            mosi_in = 1'b1;
            #1;
            total++;
            if (!ok || time_trigger !== exp_trig) begin
                bad++; $display("FAIL trig_byte%0d got=%b exp=%b", i, time_trigger, exp_trig);
            end
            total++;
            if (mark_cnt !== 8'(marks)) begin bad++; $display("FAIL trig_marks%0d got=%0d exp=%0d", i, mark_cnt, marks); end
            mosi_in = 1'b0;
            #1;
            total++;
            if (time_trigger !== 1'b0) begin bad++; $display("FAIL trig_mosi_low%0d got=%b exp=0", i, time_trigger); end
            mosi_in = 1'b1;
        end
    endtask

    task automatic test_fault();
        bit ok;
        int cnt;
        key_spoof_pulse();
        wake_up(ok);
        mem_stuck   = 1'b1;
        slave_cmd   = START;
        slave_valid = 1'b1;
        wait_state(4'd3, 20, ok);
        cnt = 0;
        while (ok && state_dbg != 4'd8 && cnt < 200) begin
            @(negedge SYSCLK);
            cnt++;
        end
        total++;
        if (!ok || cnt != FTO + 1) begin bad++; $display("FAIL fault_timeout got=%0d exp=%0d", cnt, FTO + 1); end
        @(negedge SYSCLK);
        total++;
        if ({fault, sensor_out, mem_go} !== {1'b1, 8'hFF, 1'b0}) begin
            bad++; $display("FAIL fault_outputs got=%b/%h/%b exp=1/ff/0", fault, sensor_out, mem_go);
        end
        slave_valid = 1'b0;
        csn_in = 1'b0; sclk_in = 1'b0; mosi_in = 1'b0;
        repeat (IDLEC - 5) @(negedge SYSCLK);
        total++;
        if (state_dbg !== 4'd8) begin bad++; $display("FAIL fault_early_idle got=%0d exp=8", state_dbg); end
        repeat (12) @(negedge SYSCLK);
        total++;
        if ({state_dbg, fault} !== {4'd0, 1'b1}) begin bad++; $display("FAIL fault_autoreset got=%0d/%b exp=0/1", state_dbg, fault); end
        mem_stuck = 1'b0;
        wake_up(ok);
        @(negedge SYSCLK);
        total++;
        if (!ok || fault !== 1'b0) begin bad++; $display("FAIL fault_clear got=%b exp=0", fault); end
    endtask

    task automatic test_keys();
        bit ok;
        key_spoof_pulse();
        wake_up(ok);
        long_busy   = 1'b1;
        slave_cmd   = START;
        slave_valid = 1'b1;
        wait_state(4'd4, 50, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL keys_wait_done got=%0d exp=4", state_dbg); end
        key_pass_n = 1'b0;
        @(negedge SYSCLK);
        total++;
        if ({state_dbg, mode, led} !== {4'd0, 1'b1, 2'b11}) begin
            bad++; $display("FAIL keys_pass got=%0d/%b/%b exp=0/1/11", state_dbg, mode, led);
        end
        key_spoof_n = 1'b0;
        @(negedge SYSCLK);
        total++;
        if ({mode, led} !== 3'b111) begin bad++; $display("FAIL keys_both got=%b/%b exp=1/11", mode, led); end
        key_pass_n = 1'b1;
        @(negedge SYSCLK);
        total++;
        if ({state_dbg, mode, led} !== {4'd0, 1'b0, 2'b00}) begin
            bad++; $display("FAIL keys_spoof got=%0d/%b/%b exp=0/0/00", state_dbg, mode, led);
        end
        key_spoof_n = 1'b1;
        long_busy   = 1'b0;
        slave_valid = 1'b0;
        repeat (45) @(negedge SYSCLK);
    endtask

    task automatic test_async_reset();
        bit ok;
        wake_up(ok);
        mem_stuck   = 1'b1;
        slave_cmd   = START;
        slave_valid = 1'b1;
        wait_state(4'd3, 20, ok);
        total++;
        if (!ok || {mem_go, mem_resetb} !== 2'b11) begin bad++; $display("FAIL arst_pre got=%b exp=11", {mem_go, mem_resetb}); end
        #2 resetb = 1'b0;
        #1;
        total++;
        if ({mem_go, mem_resetb, state_dbg} !== {2'b00, 4'd0}) begin
            bad++; $display("FAIL arst_abort got=%b/%0d exp=00/0", {mem_go, mem_resetb}, state_dbg);
        end
        @(negedge SYSCLK);
        resetb      = 1'b1;
        mem_stuck   = 1'b0;
        slave_valid = 1'b0;
        @(negedge SYSCLK);
    endtask

    initial begin
        test_reset();
        test_wake();
        test_replay();
        test_trigger();
        test_fault();
        test_keys();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
